// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA unit that shifts a latched operand STEP bits per cycle.
// Define ITER_SHIFTER_ROTATE_EN to add ROL/ROR, selected by rot.
module iter_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic [2:0]       funct3,
    input  logic             logic_alt,
    input  logic             rot,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam logic [SHAMT_W:0] STEP_W = SHAMT_W'(STEP) == '0 && STEP != 0 ?
                                          {1'b1, {SHAMT_W{1'b0}}} : (SHAMT_W + 1)'(STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] rem;
    logic               right;
    logic               fill;
    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   step_res;

    assign shamt = rb[SHAMT_W-1:0];

`ifdef ITER_SHIFTER_ROTATE_EN
    localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W + 1)'(WIDTH);
    logic rot_q;
    logic unused_in;
    assign unused_in = ^{rb[WIDTH-1:SHAMT_W], funct3[1:0]};
`else
    logic unused_in;
    assign unused_in = ^{rot, rb[WIDTH-1:SHAMT_W], funct3[1:0]};
`endif

    // Per-cycle step: k is at most STEP, so this is only a narrow shifter.
    always_comb begin
        k = '0;
        if ({1'b0, rem} >= STEP_W) begin
            k = STEP_W[SHAMT_W-1:0];
        end else begin
            k = rem;
        end
        if (right) begin
            step_res = (work >> k) | (fill ? ~({WIDTH{1'b1}} >> k) : '0);
        end else begin
            step_res = work << k;
        end
`ifdef ITER_SHIFTER_ROTATE_EN
        if (rot_q) begin
            if (right) begin
                step_res = (work >> k) | (work << (WIDTH_W - {1'b0, k}));
            end else begin
                step_res = (work << k) | (work >> (WIDTH_W - {1'b0, k}));
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            work      <= '0;
            rem       <= '0;
            right     <= 1'b0;
            fill      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ITER_SHIFTER_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        work     <= ra;
                        right    <= funct3[2];
                        fill     <= logic_alt & funct3[2] & ra[WIDTH-1];
                        rem      <= shamt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef ITER_SHIFTER_ROTATE_EN
                        rot_q    <= rot;
`endif
                        if (shamt == '0) begin
                            state     <= StDone;
                            out       <= ra;
                            out_valid <= 1'b1;
                        end else begin
                            state <= StShift;
                        end
                    end
                end
                StShift: begin
                    work <= step_res;
                    rem  <= rem - k;
                    if (rem == k) begin
                        state     <= StDone;
                        out       <= step_res;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter at WIDTH=32, STEP=4.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ra = '0;
    logic [31:0] rb = '0;
    logic [2:0]  funct3 = '0;
    logic        logic_alt = 1'b0;
    logic        rot = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;
    exp_t sb[$];

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ra(ra), .rb(rb), .funct3(funct3), .logic_alt(logic_alt), .rot(rot),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3, input logic alt,
                                              input logic r);
        logic [5:0] sh;
        sh = {1'b0, b[4:0]};
`ifdef ITER_SHIFTER_ROTATE_EN
        if (r) begin
            if (f3[2]) return (a >> sh) | (a << (6'd32 - sh));
            else       return (a << sh) | (a >> (6'd32 - sh));
        end
`else
        if (r) begin end
`endif
        if (!f3[2])  return a << sh;
        else if (alt) return $signed(a) >>> sh;
        else          return a >> sh;
    endfunction

    // Called at #1 after an edge with the DUT idle; returns at #1 after the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                         input logic alt, input logic r, input bit track);
        exp_t e;
        ra = a; rb = b; funct3 = f3; logic_alt = alt; rot = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ra = $urandom; rb = $urandom; funct3 = 3'($urandom); logic_alt = 1'($urandom);
        rot = 1'($urandom);
        if (track) begin
            e.val = ref_shift(a, b, f3, alt, r);
            e.lat = (int'(b[4:0]) + 3) / 4 + 1;
            sb.push_back(e);
        end
    endtask

    // Waits for out_valid (first sample is one cycle after accept), compares, pops.
    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_out"}, out, e.val);
            check({tag, "_lat"}, lat, e.lat);
        end
        if (out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #12;
        check("rst_out", out, 32'd0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        issue(32'h8000_0000, 32'd31, 3'd5, 1'b1, 1'b0, 1'b1);
        collect("sra31");
        check("sra31_idle", {31'b0, in_ready}, 32'd1);
        issue(32'h1234_5678, 32'd0, 3'd1, 1'b0, 1'b0, 1'b1);
        collect("sll0");
        issue(32'h8000_0000, 32'hFFFF_FFE4, 3'd5, 1'b0, 1'b0, 1'b1);
        collect("srl4");
        issue(32'hF0F0_F0F0, 32'd7, 3'd5, 1'b1, 1'b0, 1'b1);
        collect("sra7");
        issue(32'hF0F0_F0F0, 32'd13, 3'd5, 1'b0, 1'b0, 1'b1);
        collect("srl13");
        issue(32'hDEAD_BEEF, 32'd17, 3'd1, 1'b1, 1'b0, 1'b1);
        collect("sll17");
        issue(32'h7FFF_FFFF, 32'd30, 3'd5, 1'b1, 1'b0, 1'b1);
        collect("sra_pos30");
        issue(32'h8000_0000, 32'd32, 3'd5, 1'b1, 1'b0, 1'b1);
        collect("sra_rb32");

        // Backpressure
        out_ready = 1'b0;
        issue(32'd1, 32'd5, 3'd1, 1'b0, 1'b0, 1'b1);
        collect("bp");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_out", out, 32'h20);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush mid-operation
        issue(32'hFFFF_0000, 32'd20, 3'd5, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("fl_busy_pre", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy", {31'b0, busy}, 32'd0);
        check("fl_in_ready", {31'b0, in_ready}, 32'd1);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("fl_no_valid", seen, 32'd0);
        end
        flush = 1'b1; in_valid = 1'b1; ra = 32'd9; rb = 32'd0; funct3 = 3'd1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("fl_no_accept_busy", {31'b0, busy}, 32'd0);
        check("fl_no_accept_valid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset mid-shift
        issue(32'hABCD_0123, 32'd24, 3'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_out", out, 32'd0);
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("arst_in_ready", {31'b0, in_ready}, 32'd1);
        issue(32'd3, 32'd1, 3'd1, 1'b0, 1'b0, 1'b1);
        collect("post_rst");

`ifdef ITER_SHIFTER_ROTATE_EN
        issue(32'h0000_0001, 32'd4, 3'd5, 1'b0, 1'b1, 1'b1);
        collect("ror4");
        issue(32'h8000_0000, 32'd1, 3'd1, 1'b1, 1'b1, 1'b1);
        collect("rol1");
`else
        issue(32'h0000_0001, 32'd4, 3'd5, 1'b0, 1'b1, 1'b1);
        collect("rot_ignored");
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
